wb_stage: RTL and testbench

//  Writeback stage of the RISC-V core, directly downstream of wb_control. Holds one retiring

---
 rtl/wb_stage.sv | 217 +++++++++++++++++++++
 tb/tb_wb_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: load formatting, result mux, FPU wait with timeout
// Optional FP register-file lane enabled by defining WB_STAGE_FP_EN.
module wb_stage #(
  parameter int DWIDTH      = 32,
  parameter int FPU_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_wb_sel,
  input  logic [1:0]        in_fp_wb_sel,
  input  logic [1:0]        in_dout_sel,
  input  logic [3:0]        in_mask,
  input  logic              in_mask_un,
  input  logic              in_regwen,
  input  logic              in_fpregwen,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_fp_rd,
  input  logic [DWIDTH-1:0] in_alu,
  input  logic [DWIDTH-1:0] in_pc,
  input  logic [DWIDTH-1:0] bios_dout,
  input  logic [DWIDTH-1:0] dmem_dout,
  input  logic [DWIDTH-1:0] io_dout,
  input  logic [DWIDTH-1:0] fpu_result,
  input  logic              fpu_valid,
  output logic              fpu_ack,
  output logic              fpu_err,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  output logic              fprf_we,
  output logic [4:0]        fprf_wa,
  output logic [DWIDTH-1:0] fprf_wd
);
  localparam logic [1:0] WB_MEM    = 2'd0;
  localparam logic [1:0] WB_ALU    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  localparam logic [1:0] WB_FPU    = 2'd3;
  localparam logic [1:0] FP_WB_MEM = 2'd0;
  localparam logic [1:0] FP_WB_FPU = 2'd1;
  localparam logic [1:0] DOUT_BIOS = 2'd0;
  localparam logic [1:0] DOUT_DMEM = 2'd1;
  localparam logic [1:0] DOUT_IO   = 2'd2;
  localparam logic [7:0] TIMEOUT_LAST = 8'(FPU_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;

  logic              valid_q, valid_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q;
  logic              held_q;
  logic [DWIDTH-1:0] hold_q;
  logic [1:0]        wb_sel_q, dout_sel_q;
  logic [3:0]        mask_q;
  logic              mask_un_q, regwen_q;
  logic [4:0]        rd_q;
  logic [DWIDTH-1:0] alu_q, pc_q;

  logic              transfer, need_fpu_in, fire, timeout, lanes_go;
  logic [DWIDTH-1:0] raw_dout, mem_data, load_data, int_res;

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [3:0] m,
                                           input logic un);
    logic [31:0] r;
    r = '0;
    case (m)
      4'b0001: r = {{24{~un & d[7]}},  d[7:0]};
      4'b0010: r = {{24{~un & d[15]}}, d[15:8]};
      4'b0100: r = {{24{~un & d[23]}}, d[23:16]};
      4'b1000: r = {{24{~un & d[31]}}, d[31:24]};
      4'b0011: r = {{16{~un & d[15]}}, d[15:0]};
      4'b1100: r = {{16{~un & d[31]}}, d[31:16]};
      4'b1111: r = d;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready = (state_q == IDLE);
  assign transfer = in_valid & in_ready;

  always_comb begin
    raw_dout = '0;
    case (dout_sel_q)
      DOUT_BIOS: raw_dout = bios_dout;
      DOUT_DMEM: raw_dout = dmem_dout;
      DOUT_IO:   raw_dout = io_dout;
      default:   raw_dout = '0;
    endcase
  end

  // After the first WAIT cycle the memory has moved on; use the captured copy.
  assign mem_data  = held_q ? hold_q : raw_dout;
  assign load_data = fmt_load(mem_data, mask_q, mask_un_q);

  always_comb begin
    int_res = load_data;
    case (wb_sel_q)
      WB_ALU:  int_res = alu_q;
      WB_PC4:  int_res = pc_q + DWIDTH'(4);
      WB_FPU:  int_res = fpu_result;
      default: int_res = load_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = transfer;
    cnt_d    = '0;
    fire     = 1'b0;
    timeout  = 1'b0;
    lanes_go = 1'b0;
    case (state_q)
      IDLE: begin
        lanes_go = valid_q;
        if (transfer && need_fpu_in) state_d = WAIT;
      end
      WAIT: begin
        valid_d = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (fpu_valid) begin
          fire     = 1'b1;
          lanes_go = 1'b1;
          state_d  = IDLE;
          valid_d  = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout  = 1'b1;
          lanes_go = 1'b1;
          state_d  = IDLE;
          valid_d  = 1'b0;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fpu_ack = rst & fire;
  assign fpu_err = err_q;
  assign rf_we   = rst & lanes_go & regwen_q & (rd_q != 5'd0) & ~(timeout & (wb_sel_q == WB_FPU));
  assign rf_wa   = rd_q;
  assign rf_wd   = int_res;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      held_q     <= 1'b0;
      hold_q     <= '0;
      wb_sel_q   <= '0;
      dout_sel_q <= '0;
      mask_q     <= '0;
      mask_un_q  <= 1'b0;
      regwen_q   <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
      pc_q       <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (timeout) err_q <= 1'b1;
      if (transfer) begin
        held_q     <= 1'b0;
        wb_sel_q   <= in_wb_sel;
        dout_sel_q <= in_dout_sel;
        mask_q     <= in_mask;
        mask_un_q  <= in_mask_un;
        regwen_q   <= in_regwen;
        rd_q       <= in_rd;
        alu_q      <= in_alu;
        pc_q       <= in_pc;
      end else if (state_q == WAIT && !held_q) begin
        hold_q <= raw_dout;
        held_q <= 1'b1;
      end
    end
  end

`ifdef WB_STAGE_FP_EN
  logic [1:0] fp_wb_sel_q;
  logic       fpregwen_q;
  logic [4:0] fp_rd_q;

  assign need_fpu_in = (in_regwen & (in_wb_sel == WB_FPU)) |
                       (in_fpregwen & (in_fp_wb_sel == FP_WB_FPU));
  assign fprf_we = rst & lanes_go & fpregwen_q & ~(timeout & (fp_wb_sel_q == FP_WB_FPU));
  assign fprf_wa = fp_rd_q;
  assign fprf_wd = (fp_wb_sel_q == FP_WB_FPU) ? fpu_result : load_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fp_wb_sel_q <= FP_WB_MEM;
      fpregwen_q  <= 1'b0;
      fp_rd_q     <= '0;
    end else if (transfer) begin
      fp_wb_sel_q <= in_fp_wb_sel;
      fpregwen_q  <= in_fpregwen;
      fp_rd_q     <= in_fp_rd;
    end
  end
`else
  logic unused_fp;

  assign need_fpu_in = in_regwen & (in_wb_sel == WB_FPU);
  assign fprf_we     = 1'b0;
  assign fprf_wa     = '0;
  assign fprf_wd     = '0;
  assign unused_fp   = ^{in_fp_wb_sel, in_fpregwen, in_fp_rd, FP_WB_MEM, FP_WB_FPU};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage (FPU_TIMEOUT=4)
// Expectations adapt to WB_STAGE_FP_EN when that macro is defined.
module tb_wb_stage;
  localparam logic [1:0] WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2, WB_FPU = 2'd3;
  localparam logic [1:0] FP_WB_MEM = 2'd0, FP_WB_FPU = 2'd1;
  localparam logic [1:0] D_BIOS = 2'd0, D_DMEM = 2'd1, D_IO = 2'd2;
`ifdef WB_STAGE_FP_EN
  localparam logic FP_EN = 1'b1;
`else
  localparam logic FP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_mask_un, in_regwen, in_fpregwen, fpu_valid;
  logic [1:0] in_wb_sel, in_fp_wb_sel, in_dout_sel;
  logic [3:0] in_mask;
  logic [4:0] in_rd, in_fp_rd, rf_wa, fprf_wa;
  logic [31:0] in_alu, in_pc, bios_dout, dmem_dout, io_dout, fpu_result, rf_wd, fprf_wd;
  logic fpu_ack, fpu_err, rf_we, fprf_we;

  typedef struct packed {
    logic        rwe;
    logic [4:0]  rwa;
    logic [31:0] rwd;
    logic        fwe;
    logic [4:0]  fwa;
    logic [31:0] fwd;
    logic        ack;
  } exp_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [3:0]  mask;
    logic        un;
    logic [31:0] exp;
  } ld_t;

  exp_t sb[$];
  ld_t  ld_vec [10];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.DWIDTH(32), .FPU_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_sel(in_wb_sel), .in_fp_wb_sel(in_fp_wb_sel), .in_dout_sel(in_dout_sel),
    .in_mask(in_mask), .in_mask_un(in_mask_un), .in_regwen(in_regwen),
    .in_fpregwen(in_fpregwen), .in_rd(in_rd), .in_fp_rd(in_fp_rd),
    .in_alu(in_alu), .in_pc(in_pc), .bios_dout(bios_dout), .dmem_dout(dmem_dout),
    .io_dout(io_dout), .fpu_result(fpu_result), .fpu_valid(fpu_valid),
    .fpu_ack(fpu_ack), .fpu_err(fpu_err), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fprf_we(fprf_we), .fprf_wa(fprf_wa), .fprf_wd(fprf_wd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input logic rwe, input logic [4:0] rwa, input logic [31:0] rwd,
                               input logic fwe, input logic [4:0] fwa, input logic [31:0] fwd,
                               input logic ack);
    sb.push_back({rwe, rwa, rwd, fwe, fwa, fwd, ack});
  endfunction

  task automatic monitor();
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (rst && (rf_we || fprf_we || fpu_ack)) begin
        got = {rf_we, rf_we ? rf_wa : 5'd0, rf_we ? rf_wd : 32'd0,
               fprf_we, fprf_we ? fprf_wa : 5'd0, fprf_we ? fprf_wd : 32'd0, fpu_ack};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h expected none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL sb_write: got %h expected %h", got, e);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ncheck(input logic rdy, input logic err, input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    chk({tag, "_err"}, {31'd0, fpu_err}, {31'd0, err});
    step();
  endtask

  task automatic send(input logic [1:0] wb, input logic [1:0] fpwb, input logic [1:0] dsel,
                      input logic [3:0] m, input logic un, input logic rw, input logic fw,
                      input logic [4:0] rd, input logic [4:0] frd,
                      input logic [31:0] alu, input logic [31:0] pc);
    in_valid = 1'b1; in_wb_sel = wb; in_fp_wb_sel = fpwb; in_dout_sel = dsel;
    in_mask = m; in_mask_un = un; in_regwen = rw; in_fpregwen = fw;
    in_rd = rd; in_fp_rd = frd; in_alu = alu; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_wb_sel = '0; in_fp_wb_sel = '0; in_dout_sel = '0;
    in_mask = '0; in_mask_un = 1'b0; in_regwen = 1'b0; in_fpregwen = 1'b0;
    in_rd = '0; in_fp_rd = '0; in_alu = '0; in_pc = '0; fpu_valid = 1'b0; fpu_result = '0;
    bios_dout = 32'hDEAD_BEEF; dmem_dout = 32'h80F0_7F81; io_dout = 32'h00AB_0000;

    ld_vec[0] = {D_DMEM, 4'b0010, 1'b0, 32'h0000_007F};
    ld_vec[1] = {D_DMEM, 4'b1000, 1'b0, 32'hFFFF_FF80};
    ld_vec[2] = {D_DMEM, 4'b1100, 1'b1, 32'h0000_80F0};
    ld_vec[3] = {D_DMEM, 4'b0000, 1'b0, 32'h0000_0000};
    ld_vec[4] = {D_DMEM, 4'b0001, 1'b0, 32'hFFFF_FF81};
    ld_vec[5] = {D_DMEM, 4'b0011, 1'b0, 32'h0000_7F81};
    ld_vec[6] = {D_DMEM, 4'b1100, 1'b0, 32'hFFFF_80F0};
    ld_vec[7] = {D_BIOS, 4'b1111, 1'b0, 32'hDEAD_BEEF};
    ld_vec[8] = {D_IO,   4'b0100, 1'b1, 32'h0000_00AB};
    ld_vec[9] = {D_DMEM, 4'b0001, 1'b1, 32'h0000_0081};

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_fprf_we", {31'd0, fprf_we}, 32'd0);
    chk("rst_ack", {31'd0, fpu_ack}, 32'd0);
    chk("rst_err", {31'd0, fpu_err}, 32'd0);
    step();
    rst = 1'b1;

    push(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0);
    send(WB_ALU, FP_WB_MEM, D_DMEM, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 32'h1234, 32'd0);

    for (int i = 0; i < 10; i++) begin
      push(1'b1, 5'(i + 1), ld_vec[i].exp, FP_EN, FP_EN ? 5'(i + 16) : 5'd0,
           FP_EN ? ld_vec[i].exp : 32'd0, 1'b0);
      send(WB_MEM, FP_WB_MEM, ld_vec[i].sel, ld_vec[i].mask, ld_vec[i].un, 1'b1, 1'b1,
           5'(i + 1), 5'(i + 16), 32'd0, 32'd0);
    end

    send(WB_ALU, FP_WB_MEM, D_DMEM, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 32'h55, 32'd0);
    @(negedge clk);
    chk("rd0_rf_we", {31'd0, rf_we}, 32'd0);
    push(1'b1, 5'd1, 32'h0000_0000, 1'b0, 5'd0, 32'd0, 1'b0);
    send(WB_PC4, FP_WB_MEM, D_DMEM, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 32'd0, 32'hFFFF_FFFC);

    // integer-lane FPU result arriving on the third wait cycle
    push(1'b1, 5'd7, 32'h3F80_0000, 1'b0, 5'd0, 32'd0, 1'b1);
    send(WB_FPU, FP_WB_MEM, D_DMEM, 4'b1111, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 32'hAAAA, 32'd0);
    ncheck(1'b0, 1'b0, "fwait_c1");
    ncheck(1'b0, 1'b0, "fwait_c2");
    fpu_valid = 1'b1; fpu_result = 32'h3F80_0000;
    ncheck(1'b0, 1'b0, "fwait_c3");
    fpu_valid = 1'b0;
    ncheck(1'b1, 1'b0, "fwait_c4");

    // FADD with parallel LW; dmem changes after the first wait cycle
    push(1'b1, 5'd9, 32'h80F0_7F81, FP_EN, FP_EN ? 5'd3 : 5'd0,
         FP_EN ? 32'h4049_0FDB : 32'd0, FP_EN);
    send(WB_MEM, FP_WB_FPU, D_DMEM, 4'b1111, 1'b0, 1'b1, 1'b1, 5'd9, 5'd3, 32'd0, 32'd0);
    ncheck(~FP_EN, 1'b0, "fadd_c1");
    dmem_dout = 32'hBADB_AD00;
    ncheck(~FP_EN, 1'b0, "fadd_c2");
    fpu_valid = 1'b1; fpu_result = 32'h4049_0FDB;
    @(negedge clk);
    chk("fadd_ack", {31'd0, fpu_ack}, {31'd0, FP_EN});
    chk("fadd_c3_ready", {31'd0, in_ready}, {31'd0, ~FP_EN});
    step();
    fpu_valid = 1'b0; dmem_dout = 32'h80F0_7F81;
    ncheck(1'b1, 1'b0, "fadd_c4");

    // integer-lane timeout: nothing written, error latches
    send(WB_FPU, FP_WB_MEM, D_DMEM, 4'b1111, 1'b0, 1'b1, 1'b0, 5'd12, 5'd0, 32'd0, 32'd0);
    ncheck(1'b0, 1'b0, "to_c1");
    ncheck(1'b0, 1'b0, "to_c2");
    ncheck(1'b0, 1'b0, "to_c3");
    ncheck(1'b0, 1'b0, "to_c4");
    ncheck(1'b1, 1'b1, "to_c5");

    // reset while waiting drops the pending write
    send(WB_FPU, FP_WB_MEM, D_DMEM, 4'b1111, 1'b0, 1'b1, 1'b0, 5'd11, 5'd0, 32'd0, 32'd0);
    ncheck(1'b0, 1'b1, "rstw_c1");
    rst = 1'b0;
    step();
    rst = 1'b1; fpu_valid = 1'b1; fpu_result = 32'h1234_5678;
    @(negedge clk);
    chk("rstw_ready", {31'd0, in_ready}, 32'd1);
    chk("rstw_ack", {31'd0, fpu_ack}, 32'd0);
    chk("rstw_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rstw_err", {31'd0, fpu_err}, 32'd0);
    step();
    fpu_valid = 1'b0;

    // result arriving on the timeout cycle wins
    push(1'b1, 5'd13, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, 1'b1);
    send(WB_FPU, FP_WB_MEM, D_DMEM, 4'b1111, 1'b0, 1'b1, 1'b0, 5'd13, 5'd0, 32'd0, 32'd0);
    ncheck(1'b0, 1'b0, "win_c1");
    ncheck(1'b0, 1'b0, "win_c2");
    ncheck(1'b0, 1'b0, "win_c3");
    fpu_valid = 1'b1; fpu_result = 32'hCAFE_F00D;
    ncheck(1'b0, 1'b0, "win_c4");
    fpu_valid = 1'b0;
    ncheck(1'b1, 1'b0, "win_c5");

    // FP-lane timeout with a parallel LH: load still retires from held data
    push(1'b1, 5'd10, 32'h0000_7F81, 1'b0, 5'd0, 32'd0, 1'b0);
    send(WB_MEM, FP_WB_FPU, D_DMEM, 4'b0011, 1'b0, 1'b1, 1'b1, 5'd10, 5'd4, 32'd0, 32'd0);
    ncheck(~FP_EN, 1'b0, "fto_c1");
    dmem_dout = 32'h0000_FFFF;
    ncheck(~FP_EN, 1'b0, "fto_c2");
    ncheck(~FP_EN, 1'b0, "fto_c3");
    ncheck(~FP_EN, 1'b0, "fto_c4");
    ncheck(1'b1, FP_EN, "fto_c5");
    dmem_dout = 32'h80F0_7F81;

    fpu_valid = 1'b1; fpu_result = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("idle_fpu_ack", {31'd0, fpu_ack}, 32'd0);
    step();
    fpu_valid = 1'b0;
    step();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
